// File: rtl/mem_io_access_unit_if.sv
// Bus bundle for mem_io_access_unit: CPU request/response, word-wide memory port
// and the one-hot IO channel port.
interface mem_io_access_unit_if #(
    parameter int IO_W        = 16,
    parameter int IO_CHANNELS = 4,
    parameter int IO_SPAN     = 16
);
    localparam int OFF_W = (IO_SPAN > 1) ? $clog2(IO_SPAN) : 1;

    logic                        iReq;
    logic                        iWrite;
    logic [1:0]                  iSize;
    logic                        iUnsigned;
    logic [31:0]                 iAddress;
    logic [31:0]                 iWriteData;
    logic                        oStall;
    logic                        oDone;
    logic [31:0]                 oReadData;
    logic                        oAlignError;
    logic                        oTimeout;

    logic [31:0]                 oMemAddress;
    logic [31:0]                 oMemWriteData;
    logic [3:0]                  oMemByteEnable;
    logic                        oMemRead;
    logic                        oMemWrite;
    logic [31:0]                 iMemReadData;

    logic [IO_CHANNELS-1:0]      oIoSelect;
    logic                        oIoRead;
    logic                        oIoWrite;
    logic [OFF_W-1:0]            oIoOffset;
    logic [IO_W-1:0]             oIoWriteData;
    logic [IO_CHANNELS*IO_W-1:0] iIoReadData;
    logic [IO_CHANNELS-1:0]      iIoReady;

    modport slave (
        input  iReq, iWrite, iSize, iUnsigned, iAddress, iWriteData,
               iMemReadData, iIoReadData, iIoReady,
        output oStall, oDone, oReadData, oAlignError, oTimeout,
               oMemAddress, oMemWriteData, oMemByteEnable, oMemRead, oMemWrite,
               oIoSelect, oIoRead, oIoWrite, oIoOffset, oIoWriteData
    );

    modport master (
        output iReq, iWrite, iSize, iUnsigned, iAddress, iWriteData,
               iMemReadData, iIoReadData, iIoReady,
        input  oStall, oDone, oReadData, oAlignError, oTimeout,
               oMemAddress, oMemWriteData, oMemByteEnable, oMemRead, oMemWrite,
               oIoSelect, oIoRead, oIoWrite, oIoOffset, oIoWriteData
    );
endinterface

// File: rtl/mem_io_access_unit.sv
// Load/store unit: decodes each CPU access to fixed-latency memory or a ready-handshaked
// IO channel, handles lanes, sign extension, misalignment and IO timeout.
module mem_io_access_unit #(
    parameter int          IO_W        = 16,
    parameter int          IO_CHANNELS = 4,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FC00,
    parameter int          IO_SPAN     = 16,
    parameter int          MEM_LATENCY = 1,
    parameter int          IO_TIMEOUT  = 255
) (
    input logic                 iClock,
    input logic                 iResetN,
    mem_io_access_unit_if.slave bus
);
    localparam int          OFF_W    = (IO_SPAN > 1) ? $clog2(IO_SPAN) : 1;
    localparam int          SPAN_SH  = $clog2(IO_SPAN);
    localparam int          CH_W     = (IO_CHANNELS > 1) ? $clog2(IO_CHANNELS) : 1;
    localparam logic [32:0] IO_LIMIT = {1'b0, IO_BASE} + 33'(IO_CHANNELS * IO_SPAN);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, IO_WAIT, DONE} state_t;

    state_t           r_state;
    logic [9:0]       r_cnt;
    logic             r_write, r_unsigned;
    logic [1:0]       r_size, r_lane;
    logic [CH_W-1:0]  r_chan;

    logic             r_done, r_align_err, r_timeout;
    logic [31:0]      r_read_data, r_mem_address, r_mem_wdata;
    logic [3:0]       r_mem_be;
    logic             r_mem_read, r_mem_write;
    logic [IO_CHANNELS-1:0] r_io_select;
    logic             r_io_read, r_io_write;
    logic [OFF_W-1:0] r_io_offset;
    logic [IO_W-1:0]  r_io_wdata;

    logic [32:0]      w_io_rel;
    logic             w_is_io, w_misaligned, w_io_ready;
    logic [CH_W-1:0]  w_chan;
    logic [IO_W-1:0]  w_io_rdata;

    // 33-bit compare so a window ending at the top of the address space cannot wrap.
    assign w_io_rel     = {1'b0, bus.iAddress} - {1'b0, IO_BASE};
    assign w_is_io      = ({1'b0, bus.iAddress} >= {1'b0, IO_BASE}) && ({1'b0, bus.iAddress} < IO_LIMIT);
    assign w_chan       = CH_W'(w_io_rel >> SPAN_SH);
    assign w_misaligned = (bus.iSize == 2'b11) ||
                          (bus.iSize == 2'b01 && bus.iAddress[0]) ||
                          (bus.iSize == 2'b10 && bus.iAddress[1:0] != 2'b00);
    assign w_io_ready   = bus.iIoReady[r_chan];
    assign w_io_rdata   = bus.iIoReadData[r_chan*IO_W +: IO_W];

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   byte_enable = 4'b0001 << lane;
            2'b01:   byte_enable = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                                input logic [31:0] word, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   load_extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   load_extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    always_ff @(posedge iClock) begin
        if (!iResetN) begin
            // NOTE: every register, request fields included, is cleared so an aborted access leaves nothing behind.
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_write       <= 1'b0;
            r_unsigned    <= 1'b0;
            r_size        <= '0;
            r_lane        <= '0;
            r_chan        <= '0;
            r_done        <= 1'b0;
            r_align_err   <= 1'b0;
            r_timeout     <= 1'b0;
            r_read_data   <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_be      <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_io_select   <= '0;
            r_io_read     <= 1'b0;
            r_io_write    <= 1'b0;
            r_io_offset   <= '0;
            r_io_wdata    <= '0;
        end else begin
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                IDLE: if (bus.iReq) begin
                    r_write    <= bus.iWrite;
                    r_unsigned <= bus.iUnsigned;
                    r_size     <= bus.iSize;
                    r_lane     <= bus.iAddress[1:0];
                    r_chan     <= w_chan;
                    r_cnt      <= '0;
                    if (w_misaligned) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_align_err <= 1'b1;
                        r_read_data <= '0;
                    end else if (w_is_io) begin
                        r_state     <= IO_WAIT;
                        r_io_select <= IO_CHANNELS'(1) << w_chan;
                        r_io_offset <= OFF_W'(bus.iAddress & 32'(IO_SPAN - 1));
                        r_io_read   <= !bus.iWrite;
                        r_io_write  <= bus.iWrite;
                        r_io_wdata  <= bus.iWrite ? bus.iWriteData[IO_W-1:0] : '0;
                    end else begin
                        r_state       <= MEM_WAIT;
                        r_mem_address <= {bus.iAddress[31:2], 2'b00};
                        r_mem_be      <= byte_enable(bus.iSize, bus.iAddress[1:0]);
                        r_mem_wdata   <= bus.iWrite ? store_data(bus.iSize, bus.iWriteData) : '0;
                        r_mem_read    <= !bus.iWrite;
                        r_mem_write   <= bus.iWrite;
                    end
                end
                MEM_WAIT: begin
                    if (r_cnt == 10'(MEM_LATENCY - 1)) begin
                        r_state       <= DONE;
                        r_done        <= 1'b1;
                        r_mem_address <= '0;
                        r_mem_wdata   <= '0;
                        r_mem_be      <= '0;
                        r_mem_read    <= 1'b0;
                        r_mem_write   <= 1'b0;
                        if (!r_write)
                            r_read_data <= load_extend(r_size, r_unsigned, bus.iMemReadData, r_lane);
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                IO_WAIT: begin
                    if (w_io_ready || r_cnt == 10'(IO_TIMEOUT - 1)) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_io_select <= '0;
                        r_io_offset <= '0;
                        r_io_read   <= 1'b0;
                        r_io_write  <= 1'b0;
                        r_io_wdata  <= '0;
                        // IO data always arrives on lane 0, whatever the byte address.
                        if (!w_io_ready) begin
                            r_timeout   <= 1'b1;
                            r_read_data <= '0;
                        end else if (!r_write) begin
                            r_read_data <= load_extend(r_size, r_unsigned, 32'(w_io_rdata), 2'b00);
                        end
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.oStall         = (r_state == IDLE && bus.iReq) || r_state == MEM_WAIT || r_state == IO_WAIT;
    assign bus.oDone          = r_done;
    assign bus.oAlignError    = r_align_err;
    assign bus.oTimeout       = r_timeout;
    assign bus.oReadData      = r_read_data;
    assign bus.oMemAddress    = r_mem_address;
    assign bus.oMemWriteData  = r_mem_wdata;
    assign bus.oMemByteEnable = r_mem_be;
    assign bus.oMemRead       = r_mem_read;
    assign bus.oMemWrite      = r_mem_write;
    assign bus.oIoSelect      = r_io_select;
    assign bus.oIoRead        = r_io_read;
    assign bus.oIoWrite       = r_io_write;
    assign bus.oIoOffset      = r_io_offset;
    assign bus.oIoWriteData   = r_io_wdata;
endmodule

// File: tb/tb_mem_io_access_unit.sv
// Randomized bench for mem_io_access_unit: a transaction-level model predicts every
// output on every cycle, and directed accesses pin the model to hand-computed values.
module tb_mem_io_access_unit;
    localparam int          IO_W        = 16;
    localparam int          IO_CHANNELS = 4;
    localparam int          IO_SPAN     = 16;
    localparam int          MEM_LATENCY = 1;
    localparam int          IO_TIMEOUT  = 8;
    localparam logic [31:0] IO_BASE     = 32'hFFFF_FC00;
    localparam int          NEVER       = 1000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_io_access_unit_if #(.IO_W(IO_W), .IO_CHANNELS(IO_CHANNELS), .IO_SPAN(IO_SPAN)) bus ();

    mem_io_access_unit #(
        .IO_W(IO_W), .IO_CHANNELS(IO_CHANNELS), .IO_BASE(IO_BASE), .IO_SPAN(IO_SPAN),
        .MEM_LATENCY(MEM_LATENCY), .IO_TIMEOUT(IO_TIMEOUT)
    ) dut (
        .iClock (clk),
        .iResetN(rst_n),
        .bus    (bus.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    bit          check_en = 1'b0;
    int          cyc      = 0;

    logic        exp_stall, exp_done, exp_align, exp_tmo;
    logic        exp_mrd, exp_mwr, exp_iord, exp_iowr;
    logic [31:0] exp_rdata, exp_maddr, exp_mwdata;
    logic [3:0]  exp_be, exp_sel, exp_off;
    logic [15:0] exp_iowdata;
    logic [31:0] cur_rdata = '0;

    int          mon_stall_cnt = 0, mon_strobe_cnt = 0, mon_mwr_cnt = 0;
    int          mon_done_cnt = 0, mon_done_cyc = 0, mon_tmo_cnt = 0, mon_align_cnt = 0;
    logic [3:0]  mon_be = '0, mon_sel = '0;
    logic [31:0] mon_mwdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (check_en) begin
            check("oStall",         32'(bus.oStall),         32'(exp_stall));
            check("oDone",          32'(bus.oDone),          32'(exp_done));
            check("oAlignError",    32'(bus.oAlignError),    32'(exp_align));
            check("oTimeout",       32'(bus.oTimeout),       32'(exp_tmo));
            check("oReadData",      bus.oReadData,           exp_rdata);
            check("oMemAddress",    bus.oMemAddress,         exp_maddr);
            check("oMemWriteData",  bus.oMemWriteData,       exp_mwdata);
            check("oMemByteEnable", 32'(bus.oMemByteEnable), 32'(exp_be));
            check("oMemRead",       32'(bus.oMemRead),       32'(exp_mrd));
            check("oMemWrite",      32'(bus.oMemWrite),      32'(exp_mwr));
            check("oIoSelect",      32'(bus.oIoSelect),      32'(exp_sel));
            check("oIoRead",        32'(bus.oIoRead),        32'(exp_iord));
            check("oIoWrite",       32'(bus.oIoWrite),       32'(exp_iowr));
            check("oIoOffset",      32'(bus.oIoOffset),      32'(exp_off));
            check("oIoWriteData",   32'(bus.oIoWriteData),   32'(exp_iowdata));
            if (bus.oStall) mon_stall_cnt <= mon_stall_cnt + 1;
            if (bus.oMemRead || bus.oMemWrite || bus.oIoRead || bus.oIoWrite)
                mon_strobe_cnt <= mon_strobe_cnt + 1;
            if (bus.oMemWrite) mon_mwr_cnt <= mon_mwr_cnt + 1;
            if (bus.oMemRead || bus.oMemWrite) begin
                mon_be     <= bus.oMemByteEnable;
                mon_mwdata <= bus.oMemWriteData;
            end
            if (bus.oIoSelect != '0) mon_sel <= bus.oIoSelect;
            if (bus.oDone) begin
                mon_done_cnt <= mon_done_cnt + 1;
                mon_done_cyc <= cyc;
            end
            if (bus.oDone && bus.oTimeout)    mon_tmo_cnt   <= mon_tmo_cnt + 1;
            if (bus.oDone && bus.oAlignError) mon_align_cnt <= mon_align_cnt + 1;
        end
    end

    task automatic clear_exp();
        exp_stall = 0; exp_done = 0; exp_align = 0; exp_tmo = 0;
        exp_mrd = 0; exp_mwr = 0; exp_iord = 0; exp_iowr = 0;
        exp_rdata = cur_rdata; exp_maddr = '0; exp_mwdata = '0;
        exp_be = '0; exp_sel = '0; exp_off = '0; exp_iowdata = '0;
    endtask

    task automatic random_env();
        bus.iMemReadData = $urandom;
        bus.iIoReadData  = {$urandom, $urandom};
        bus.iIoReady     = 4'($urandom);
    endtask

    task automatic random_cpu();
        bus.iReq       = 1'($urandom);
        bus.iWrite     = 1'($urandom);
        bus.iSize      = 2'($urandom);
        bus.iUnsigned  = 1'($urandom);
        bus.iAddress   = $urandom;
        bus.iWriteData = $urandom;
        random_env();
    endtask

    task automatic idle_inputs();
        random_cpu();
        bus.iReq = 1'b0;
    endtask

    // One CPU access from request to the following idle cycle; abort_at>0 pulses reset on that wait cycle.
    task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] payload, input int rdy_delay,
                          input int abort_at, output int req_cyc);
        bit          mis, is_io, tmo;
        int          ch, n_wait;
        longint      rel;
        logic [31:0] shifted, val, rep;
        logic [3:0]  be;

        mis    = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0);
        rel    = longint'(addr) - longint'(IO_BASE);
        is_io  = !mis && rel >= 0 && rel < IO_CHANNELS * IO_SPAN;
        ch     = is_io ? int'(rel / IO_SPAN) : 0;
        tmo    = is_io && rdy_delay > IO_TIMEOUT;
        n_wait = mis ? 0 : (!is_io ? MEM_LATENCY : (tmo ? IO_TIMEOUT : rdy_delay));

        shifted = is_io ? (payload & 32'hFFFF) : (payload >> (8 * (addr % 4)));
        case (sz)
            2'd0: begin val = shifted & 32'hFF;   if (!uns && val >= 32'd128)   val = val - 32'd256;   end
            2'd1: begin val = shifted & 32'hFFFF; if (!uns && val >= 32'd32768) val = val - 32'd65536; end
            default: val = shifted;
        endcase
        case (sz)
            2'd0:    begin be = 4'(32'd1 << (addr % 4)); rep = (wdata & 32'hFF) * 32'h0101_0101; end
            2'd1:    begin be = 4'(32'd3 << (addr % 4)); rep = (wdata & 32'hFFFF) * 32'h0001_0001; end
            default: begin be = 4'hF;                    rep = wdata; end
        endcase

        random_env();
        bus.iReq = 1'b1; bus.iWrite = wr; bus.iSize = sz; bus.iUnsigned = uns;
        bus.iAddress = addr; bus.iWriteData = wdata;
        clear_exp();
        exp_stall = 1'b1;
        req_cyc = cyc;
        @(posedge clk); #1;

        for (int k = 1; k <= n_wait; k++) begin
            random_cpu();
            if (!is_io && k == n_wait) bus.iMemReadData = payload;
            if (is_io) begin
                bus.iIoReady[ch] = (k == rdy_delay);
                if (k == rdy_delay) bus.iIoReadData[ch*IO_W +: IO_W] = payload[15:0];
            end
            clear_exp();
            exp_stall = 1'b1;
            if (is_io) begin
                exp_sel     = 4'(32'd1 << ch);
                exp_off     = 4'(addr % IO_SPAN);
                exp_iord    = !wr;
                exp_iowr    = wr;
                exp_iowdata = wr ? wdata[15:0] : 16'h0;
            end else begin
                exp_maddr  = addr & ~32'd3;
                exp_be     = be;
                exp_mwdata = wr ? rep : 32'h0;
                exp_mrd    = !wr;
                exp_mwr    = wr;
            end
            if (k == abort_at) rst_n = 1'b0;
            @(posedge clk); #1;
            if (k == abort_at) begin
                rst_n = 1'b1;
                idle_inputs();
                cur_rdata = '0;
                clear_exp();
                return;
            end
        end

        random_cpu();
        if (mis || tmo)  cur_rdata = '0;
        else if (!wr)    cur_rdata = val;
        clear_exp();
        exp_done  = 1'b1;
        exp_align = mis;
        exp_tmo   = tmo;
        @(posedge clk); #1;
        idle_inputs();
        clear_exp();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          rc, base;
        logic [31:0] addr;
        logic [1:0]  sz;
        int          r;
        logic [31:0] edge_addrs [5];

        edge_addrs = '{IO_BASE - 32'd4, IO_BASE - 32'd1, IO_BASE + 32'd64, IO_BASE + 32'd63, 32'hFFFF_FFFC};

        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        clear_exp();
        check_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Signed byte load from the top lane.
        access(1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0, 32'h80FF_0000, 0, 0, rc);
        check("lit_lb_be", 32'(mon_be), 32'h8);
        check("lit_lb_rdata", bus.oReadData, 32'hFFFF_FF80);
        check("lit_lb_done_cycle", 32'(mon_done_cyc - rc + 1), 32'd3);

        // Halfword store to the upper half.
        base = mon_mwr_cnt;
        access(1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h1234_ABCD, $urandom, 0, 0, rc);
        check("lit_sh_be", 32'(mon_be), 32'hC);
        check("lit_sh_wdata", mon_mwdata, 32'hABCD_ABCD);
        check("lit_sh_write_cycles", 32'(mon_mwr_cnt - base), 32'd1);
        check("lit_sh_rdata_kept", bus.oReadData, 32'hFFFF_FF80);

        // IO word load, channel 1, ready on the third wait cycle.
        base = mon_stall_cnt;
        access(1'b0, 2'd2, 1'b0, 32'hFFFF_FC10, 32'h0, 32'h0000_8001, 3, 0, rc);
        check("lit_io_select", 32'(mon_sel), 32'h2);
        check("lit_io_rdata", bus.oReadData, 32'h0000_8001);
        check("lit_io_stall_cycles", 32'(mon_stall_cnt - base), 32'd4);

        // Misaligned word load.
        base = mon_strobe_cnt;
        r = mon_align_cnt;
        access(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, $urandom, 0, 0, rc);
        check("lit_align_strobes", 32'(mon_strobe_cnt - base), 32'd0);
        check("lit_align_flag", 32'(mon_align_cnt - r), 32'd1);
        check("lit_align_rdata", bus.oReadData, 32'h0);

        // IO timeout on channel 2.
        base = mon_tmo_cnt;
        access(1'b0, 2'd2, 1'b0, 32'hFFFF_FC20, 32'h0, $urandom, NEVER, 0, rc);
        check("lit_tmo_flag", 32'(mon_tmo_cnt - base), 32'd1);
        check("lit_tmo_done_cycle", 32'(mon_done_cyc - rc + 1), 32'd10);
        check("lit_tmo_rdata", bus.oReadData, 32'h0);

        // Signed half load, then the same timeout access aborted by reset.
        access(1'b0, 2'd1, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_8000, 0, 0, rc);
        check("lit_lh_rdata", bus.oReadData, 32'hFFFF_8000);
        base = mon_done_cnt;
        access(1'b0, 2'd2, 1'b0, 32'hFFFF_FC20, 32'h0, $urandom, NEVER, 3, rc);
        repeat (4) begin @(posedge clk); #1; end
        check("lit_abort_no_done", 32'(mon_done_cnt - base), 32'd0);
        check("lit_abort_rdata", bus.oReadData, 32'h0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    addr = $urandom;
                2:       addr = IO_BASE + 32'($urandom_range(0, IO_CHANNELS * IO_SPAN - 1));
                default: addr = edge_addrs[$urandom_range(0, 4)];
            endcase
            r  = $urandom_range(0, 7);
            sz = (r == 7) ? 2'd3 : 2'(r % 3);
            if ($urandom_range(0, 3) != 0)
                addr = addr & ~32'((sz == 2'd1) ? 1 : (sz == 2'd2) ? 3 : 0);
            access(1'($urandom), sz, 1'($urandom), addr, $urandom, $urandom,
                   $urandom_range(1, IO_TIMEOUT + 2), 0, rc);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (2) begin @(posedge clk); #1; end
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
